// File: rtl/spi_master_if.sv
// SPI master byte handshake plus SPI pin bundle.
// The master modport is the spi_master view; the slave modport is the
// view of whatever feeds bytes in and owns the MISO line.
interface spi_master_if;
    logic       i_tx_valid;
    logic [7:0] i_tx_byte;
    logic       o_tx_ready;
    logic       i_cs_hold;
    logic       o_rx_valid;
    logic [7:0] o_rx_byte;
    logic       o_sck;
    logic       o_mosi;
    logic       i_miso;
    logic       o_cs_n;

    modport master (
        input  i_tx_valid, i_tx_byte, i_cs_hold, i_miso,
        output o_tx_ready, o_rx_valid, o_rx_byte, o_sck, o_mosi, o_cs_n
    );

    modport slave (
        output i_tx_valid, i_tx_byte, i_cs_hold, i_miso,
        input  o_tx_ready, o_rx_valid, o_rx_byte, o_sck, o_mosi, o_cs_n
    );
endinterface

// File: rtl/spi_master.sv
// SPI mode-0 initiator, MSB first, full duplex byte transfers.
// SCK half-period is CLKS_PER_HALF_BIT system clocks; CS can be held
// low across bytes through i_cs_hold. All outputs are registered.
module spi_master #(
    parameter int unsigned CLKS_PER_HALF_BIT = 2
) (
    input  logic         i_clk,
    input  logic         i_sys_rst,
    spi_master_if.master bus
);
    localparam logic [7:0] HALF_MAX   = 8'(CLKS_PER_HALF_BIT - 1);
    localparam logic [4:0] LAST_EDGE  = 5'd16;
    localparam logic [4:0] FINAL_RISE = 5'd15;

    typedef enum logic [2:0] {IDLE, LEAD, XFER, HOLD, TRAIL} state_e;

    state_e     state_q, state_d;
    logic [7:0] half_cnt_q, half_cnt_d;
    logic [4:0] edge_cnt_q, edge_cnt_d;
    logic [7:0] tx_sr_q, tx_sr_d;
    logic [7:0] rx_sr_q, rx_sr_d;
    logic [7:0] rx_byte_q, rx_byte_d;
    logic       cs_n_q, cs_n_d;
    logic       sck_q, sck_d;
    logic       mosi_q, mosi_d;
    logic       ready_q, ready_d;
    logic       rx_valid_q, rx_valid_d;
    logic       accept;
    logic       half_done;

    assign accept    = bus.i_tx_valid && ready_q;
    assign half_done = (half_cnt_q == HALF_MAX);

    // Next-state, counter, shift-register and pin logic.
    always_comb begin
        state_d    = state_q;
        half_cnt_d = half_cnt_q;
        edge_cnt_d = edge_cnt_q;
        tx_sr_d    = tx_sr_q;
        rx_sr_d    = rx_sr_q;
        rx_byte_d  = rx_byte_q;
        cs_n_d     = cs_n_q;
        sck_d      = sck_q;
        mosi_d     = mosi_q;
        rx_valid_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                cs_n_d = 1'b1;
                sck_d  = 1'b0;
                mosi_d = 1'b1;
                if (accept) begin
                    tx_sr_d    = {bus.i_tx_byte[6:0], 1'b0};
                    mosi_d     = bus.i_tx_byte[7];
                    cs_n_d     = 1'b0;
                    half_cnt_d = '0;
                    state_d    = LEAD;
                end
            end
            // CS setup time; its last cycle produces the first SCK rise.
            LEAD: begin
                if (half_done) begin
                    half_cnt_d = '0;
                    edge_cnt_d = 5'd1;
                    sck_d      = 1'b1;
                    rx_sr_d    = {rx_sr_q[6:0], bus.i_miso};
                    state_d    = XFER;
                end else begin
                    half_cnt_d = half_cnt_q + 8'd1;
                end
            end
            XFER: begin
                if (edge_cnt_q == LAST_EDGE) begin
                    rx_valid_d = 1'b1;
                    rx_byte_d  = rx_sr_q;
                    half_cnt_d = '0;
                    state_d    = TRAIL;
                end else if (half_done) begin
                    half_cnt_d = '0;
                    edge_cnt_d = edge_cnt_q + 5'd1;
                    sck_d      = !sck_q;
                    if (!sck_q) begin
                        rx_sr_d = {rx_sr_q[6:0], bus.i_miso};
                    end else if (edge_cnt_q != FINAL_RISE) begin
                        mosi_d  = tx_sr_q[7];
                        tx_sr_d = {tx_sr_q[6:0], 1'b0};
                    end
                end else begin
                    half_cnt_d = half_cnt_q + 8'd1;
                end
            end
            HOLD: begin
                if (accept) begin
                    tx_sr_d    = {bus.i_tx_byte[6:0], 1'b0};
                    mosi_d     = bus.i_tx_byte[7];
                    half_cnt_d = '0;
                    edge_cnt_d = '0;
                    state_d    = XFER;
                end else if (!bus.i_cs_hold) begin
                    half_cnt_d = '0;
                    state_d    = TRAIL;
                end
            end
            // The rx_valid cycle doubles as the first TRAIL cycle; the hold
            // decision is taken there so the no-hold path keeps its timing.
            TRAIL: begin
                if (rx_valid_q && bus.i_cs_hold) begin
                    half_cnt_d = '0;
                    state_d    = HOLD;
                end else if (half_done) begin
                    half_cnt_d = '0;
                    cs_n_d     = 1'b1;
                    mosi_d     = 1'b1;
                    state_d    = IDLE;
                end else begin
                    half_cnt_d = half_cnt_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        ready_d = (state_d == IDLE) || (state_d == HOLD);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge i_clk) begin
        if (!i_sys_rst) begin
            state_q    <= IDLE;
            half_cnt_q <= '0;
            edge_cnt_q <= '0;
            tx_sr_q    <= '0;
            rx_sr_q    <= '0;
            rx_byte_q  <= '0;
            cs_n_q     <= 1'b1;
            sck_q      <= 1'b0;
            mosi_q     <= 1'b1;
            ready_q    <= 1'b0;
            rx_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            half_cnt_q <= half_cnt_d;
            edge_cnt_q <= edge_cnt_d;
            tx_sr_q    <= tx_sr_d;
            rx_sr_q    <= rx_sr_d;
            rx_byte_q  <= rx_byte_d;
            cs_n_q     <= cs_n_d;
            sck_q      <= sck_d;
            mosi_q     <= mosi_d;
            ready_q    <= ready_d;
            rx_valid_q <= rx_valid_d;
        end
    end

    assign bus.o_tx_ready = ready_q;
    assign bus.o_rx_valid = rx_valid_q;
    assign bus.o_rx_byte  = rx_byte_q;
    assign bus.o_sck      = sck_q;
    assign bus.o_mosi     = mosi_q;
    assign bus.o_cs_n     = cs_n_q;
endmodule
